// File: rtl/resnet_conv_pkg.sv
// Shared constants, FSM states and output clamp for the residual 3x3 conv block.
package resnet_conv_pkg;
  localparam int DW    = 16;
  localparam int K     = 3;
  localparam int KK    = K * K;
  localparam int ACC_W = 32;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd32767;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

  // ReLU then clamp to the positive DW-bit range
  function automatic logic [ACC_W-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    if (acc < 0) return '0;
    if (acc > SAT_MAX) return SAT_MAX;
    return acc;
  endfunction
endpackage

// File: rtl/resnet_line_buffer.sv
// Two-row line buffer plus 3x3 window; column kx=2 is the newest pixel.
module resnet_line_buffer #(
  parameter int IMG_W = 8,
  parameter int DW    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        shift_i,
  input  logic [$clog2(IMG_W)-1:0]    x_i,
  input  logic [DW-1:0]               pix_i,
  output logic [2:0][2:0][DW-1:0]     win_o
);
  import resnet_conv_pkg::*;

  logic [IMG_W-1:0][DW-1:0] row1_q, row2_q;  // rows y-1 and y-2
  logic [K-1:0][K-1:0][DW-1:0] win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row1_q <= '0;
      row2_q <= '0;
      win_q  <= '0;
    end else if (shift_i) begin
      row2_q[x_i] <= row1_q[x_i];
      row1_q[x_i] <= pix_i;
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K-1; kx++)
          win_q[ky][kx] <= win_q[ky][kx+1];
      win_q[0][K-1] <= row2_q[x_i];
      win_q[1][K-1] <= row1_q[x_i];
      win_q[2][K-1] <= pix_i;
    end
  end

  assign win_o = win_q;
endmodule

// File: rtl/resnet_conv_accel.sv
// Residual 3x3 conv: load 9 weights, stream one frame, emit ReLU(conv + centre) saturated.
module resnet_conv_accel #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  input  logic [DW-1:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read [0:0],
  output logic          hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en,
  input  logic [DW-1:0] hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read [0:0],
  output logic          hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
  output logic [DW-1:0] hw_output_stencil_op_hcompute_hw_output_stencil_write [0:0]
);
  import resnet_conv_pkg::*;

  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int STAGES = 2;

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;  // weight index in LOAD_W, cycle in DRAIN
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  logic                        ker_en, pix_en, win_vld;
  logic [STAGES:0]             vld_pipe_q;    // [0] window, [1] products, [2] output
  logic [KK-1:0][DW-1:0]       w_q;
  logic [K-1:0][K-1:0][DW-1:0] win;
  logic signed [ACC_W-1:0]     prod_q [KK];
  logic signed [ACC_W-1:0]     ctr_q, acc;
  logic [DW-1:0]               wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    ker_en  = 1'b0;
    pix_en  = 1'b0;
    case (state_q)
      LOAD_W: begin
        ker_en = 1'b1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(KK-1)) begin
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        pix_en = 1'b1;
        x_d    = x_q + 1'b1;
        if (x_q == XW'(IMG_W-1)) begin
          x_d = '0;
          y_d = y_q + 1'b1;
          if (y_q == YW'(IMG_H-1)) begin
            y_d     = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: ;
    endcase
    // Restart wins over everything, including in-flight reads
    if (flush) begin
      state_d = LOAD_W;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      ker_en  = 1'b0;
      pix_en  = 1'b0;
    end
  end

  assign win_vld = pix_en && (x_q >= XW'(2)) && (y_q >= YW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      if (ker_en) w_q[cnt_q] <= hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read[0];
      vld_pipe_q <= flush ? '0 : {vld_pipe_q[STAGES-1:0], win_vld};
    end
  end

  resnet_line_buffer #(.IMG_W(IMG_W), .DW(DW)) u_lb (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (pix_en),
    .x_i     (x_q),
    .pix_i   (hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read[0]),
    .win_o   (win)
  );

  always_comb begin
    acc = ctr_q;
    for (int k = 0; k < KK; k++) acc = acc + prod_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KK; k++) prod_q[k] <= '0;
      ctr_q <= '0;
      wr_q  <= '0;
    end else begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          prod_q[ky*K+kx] <= ACC_W'(signed'(w_q[ky*K+kx])) * ACC_W'(signed'(win[ky][kx]));
      ctr_q <= ACC_W'(signed'(win[1][1]));
      wr_q  <= (vld_pipe_q[1] && !flush) ? DW'(relu_sat(acc)) : '0;
    end
  end

  assign hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en = ker_en;
  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en   = pix_en;
  assign hw_output_stencil_op_hcompute_hw_output_stencil_write_valid            = vld_pipe_q[STAGES];
  assign hw_output_stencil_op_hcompute_hw_output_stencil_write[0]               = wr_q;
endmodule

// File: tb/tb_resnet_conv_accel.sv
// Randomized frames against a plain-arithmetic conv/ReLU/saturate model with latency tracking.
module tb_resnet_conv_accel;
  localparam int W = 8, H = 8, DW = 16;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [DW-1:0] in_rd [0:0];
  logic [DW-1:0] k_rd  [0:0];
  logic [DW-1:0] wr    [0:0];
  logic in_en, k_en, wr_vld;

  always #5 clk = ~clk;

  resnet_conv_accel #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en   (in_en),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read      (in_rd),
    .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en (k_en),
    .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read    (k_rd),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid            (wr_vld),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write                  (wr)
  );

  int kmem [9];
  int pmem [NPIX];
  int kidx, pidx, cyc, kcnt, icnt, ocnt;
  int checks = 0, errors = 0;
  int exp_q [$];
  int samp_q [$];
  int got_q [$];
  int prev_q [$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  assign k_rd[0]  = DW'(kmem[kidx % 9]);
  assign in_rd[0] = DW'(pmem[pidx % NPIX]);

  // Sources advance only on edges where the DUT pops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kidx <= 0;
      pidx <= 0;
    end else if (flush) begin
      kidx <= 0;
      pidx <= 0;
    end else begin
      if (k_en)  kidx <= kidx + 1;
      if (in_en) pidx <= pidx + 1;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (k_en) kcnt++;
    if (in_en) begin
      icnt++;
      if ((pidx % W) >= 2 && (pidx / W) >= 2) samp_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_vld) begin
        ocnt++;
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else begin
          chk("out_data", int'(wr[0]), exp_q.pop_front());
          chk("out_lat", samp_q.size() > 0 ? cyc - samp_q.pop_front() : -1, 2);
          got_q.push_back(int'(wr[0]));
        end
      end else if (wr[0] != '0) chk("idle_data", int'(wr[0]), 0);
    end
  end

  task automatic build_model();
    int acc;
    exp_q.delete();
    for (int y = 2; y < H; y++)
      for (int x = 2; x < W; x++) begin
        acc = pmem[(y-1)*W + x-1];
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            acc += kmem[ky*3+kx] * pmem[(y-2+ky)*W + x-2+kx];
        exp_q.push_back(acc < 0 ? 0 : (acc > 32767 ? 32767 : acc));
      end
  endtask

  task automatic start_frame();
    @(negedge clk);
    #1;
    flush = 1'b1;
    samp_q.delete();
    got_q.delete();
    kcnt = 0; icnt = 0; ocnt = 0;
    build_model();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (ocnt < NOUT && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_timeout"}, int'(n < 300), 1);
    chk({tag, "_kcnt"}, kcnt, 9);
    chk({tag, "_icnt"}, icnt, NPIX);
    chk({tag, "_ocnt"}, ocnt, NOUT);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_icnt(input int n);
    int c = 0;
    while (icnt < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("icnt_reach", int'(icnt >= n), 1);
  endtask

  initial begin
    cyc = 0; kcnt = 0; icnt = 0; ocnt = 0;
    for (int k = 0; k < 9; k++) kmem[k] = 0;
    for (int p = 0; p < NPIX; p++) pmem[p] = 0;
    repeat (2) @(negedge clk);
    chk("rst_kren", int'(k_en), 0);
    chk("rst_inen", int'(in_en), 0);
    chk("rst_wv", int'(wr_vld), 0);
    chk("rst_wr", int'(wr[0]), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_rd", kcnt + icnt, 0);

    // Counting sources: hand-computed anchors
    for (int k = 0; k < 9; k++) kmem[k] = k;
    for (int p = 0; p < NPIX; p++) pmem[p] = p;
    start_frame();
    wait_done("count");
    chk("first_out", got_q.size() > 0  ? got_q[0]  : -1, 483);
    chk("second_out", got_q.size() > 1 ? got_q[1]  : -1, 520);
    chk("row1_out", got_q.size() > 6   ? got_q[6]  : -1, 779);
    chk("last_out", got_q.size() > 35  ? got_q[35] : -1, 2148);

    for (int k = 0; k < 9; k++) kmem[k] = -1;
    for (int p = 0; p < NPIX; p++) pmem[p] = 1;
    start_frame();
    wait_done("relu");
    chk("relu_val", got_q.size() > 0 ? got_q[0] : -1, 0);

    for (int k = 0; k < 9; k++) kmem[k] = 1000;
    for (int p = 0; p < NPIX; p++) pmem[p] = 100;
    start_frame();
    wait_done("sat");
    chk("sat_val", got_q.size() > 0 ? got_q[0] : -1, 32767);

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 9; k++) kmem[k] = int'($urandom_range(0, 40)) - 20;
      for (int p = 0; p < NPIX; p++) pmem[p] = int'($urandom_range(0, 300)) - 100;
      start_frame();
      wait_done("rand_small");
    end
    for (int k = 0; k < 9; k++) kmem[k] = rnd16();
    for (int p = 0; p < NPIX; p++) pmem[p] = rnd16();
    start_frame();
    wait_done("rand_full");

    // Restart mid-stream, then repeat after DONE
    for (int k = 0; k < 9; k++) kmem[k] = int'($urandom_range(0, 20)) - 5;
    for (int p = 0; p < NPIX; p++) pmem[p] = int'($urandom_range(0, 200)) - 50;
    start_frame();
    wait_icnt(30);
    start_frame();
    wait_done("reflush");
    prev_q = got_q;
    start_frame();
    wait_done("repeat");
    chk("repeat_len", got_q.size(), prev_q.size());
    for (int i = 0; i < got_q.size() && i < prev_q.size(); i++) chk("repeat_val", got_q[i], prev_q[i]);

    // Async reset mid-frame
    start_frame();
    wait_icnt(20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_kren", int'(k_en), 0);
    chk("mrst_inen", int'(in_en), 0);
    chk("mrst_wv", int'(wr_vld), 0);
    chk("mrst_wr", int'(wr[0]), 0);
    exp_q.delete();
    samp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    kcnt = 0; icnt = 0;
    repeat (4) @(negedge clk);
    chk("mrst_idle", kcnt + icnt, 0);
    start_frame();
    wait_done("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
